// File: rtl/instr_decode_pkg.sv
// Shared definitions for the ID stage: opcode/funct constants, ALU operation
// encodings, and the layout of the ID/EX control bundle.
//   ctrl bundle = {alu_op[3:0], reg_write, mem_read, mem_write, mem_to_reg, alu_src}
package instr_decode_pkg;

  localparam int CTRL_W = 9;

  // Bit positions inside the control bundle
  localparam int CTRL_ALU_SRC    = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_ALU_LSB    = 5;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6
  } alu_op_e;

  // Assemble a control bundle in the fixed field order
  function automatic logic [CTRL_W-1:0] pack_ctrl(input alu_op_e op, input logic reg_write,
                                                  input logic mem_read, input logic mem_write,
                                                  input logic mem_to_reg, input logic alu_src);
    return {op, reg_write, mem_read, mem_write, mem_to_reg, alu_src};
  endfunction

endpackage

// File: rtl/instr_decode_reg_file.sv
// 32x32 register file for the ID stage.
//   clk, rst_n        : clock and asynchronous active-low clear of all registers
//   we, waddr, wdata  : writeback port (writes to r0 are ignored)
//   raddr_a/b         : combinational read addresses
//   rdata_a/b         : read data; r0 reads 0, a same-cycle write is forwarded
module instr_decode_reg_file #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs_r [NREGS];

  // Register array: async clear, write on the edge unless targeting r0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (waddr != {REG_ADDR_W{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Write-through: the read address being nonzero guarantees the write is real
  assign rdata_a = (raddr_a == {REG_ADDR_W{1'b0}}) ? {DATA_W{1'b0}} :
                   (we && (waddr == raddr_a))       ? wdata : regs_r[raddr_a];
  assign rdata_b = (raddr_b == {REG_ADDR_W{1'b0}}) ? {DATA_W{1'b0}} :
                   (we && (waddr == raddr_b))       ? wdata : regs_r[raddr_b];

endmodule

// File: rtl/instr_decode.sv
// ID stage: decodes the fetched instruction, reads the register file,
// detects load-use and branch-operand hazards, resolves branches/jumps and
// registers the ID/EX bundle.
//   instr_87/npc_87                  : instruction and its PC+4 from fetch
//   wb_we_87/wb_addr_87/wb_data_87   : register writeback
//   mem_reg_write_87/mem_dst_87      : EX/MEM pending destination (branch hazard)
//   stall_87/flush_87/sel_87/pc_87   : combinational control back to fetch
//   id_*                             : registered ID/EX bundle
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                   clk_87,
  input  logic                   rst_n_87,
  input  logic [INSTR_WIDTH-1:0] instr_87,
  input  logic [ADDR_WIDTH-1:0]  npc_87,
  input  logic                   wb_we_87,
  input  logic [REG_ADDR_W-1:0]  wb_addr_87,
  input  logic [31:0]            wb_data_87,
  input  logic                   mem_reg_write_87,
  input  logic [REG_ADDR_W-1:0]  mem_dst_87,
  output logic                   stall_87,
  output logic                   flush_87,
  output logic                   sel_87,
  output logic [ADDR_WIDTH-1:0]  pc_87,
  output logic [CTRL_W-1:0]      id_ctrl_87,
  output logic [31:0]            id_rs_val_87,
  output logic [31:0]            id_rt_val_87,
  output logic [31:0]            id_imm_87,
  output logic [REG_ADDR_W-1:0]  id_rs_87,
  output logic [REG_ADDR_W-1:0]  id_rt_87,
  output logic [REG_ADDR_W-1:0]  id_dst_87,
  output logic [ADDR_WIDTH-1:0]  id_npc_87
);

  localparam logic [REG_ADDR_W-1:0] R0 = {REG_ADDR_W{1'b0}};

  logic [5:0]            op_s, funct_s;
  logic [REG_ADDR_W-1:0] rs_s, rt_s, rd_s, dst_s;
  logic [31:0]           imm_s, rs_val_s, rt_val_s;
  logic [CTRL_W-1:0]     ctrl_s;
  logic                  nop_s, reads_rs_s, reads_rt_s, is_beq_s, is_bne_s, is_j_s;
  logic                  load_use_s, rs_hit_s, rt_hit_s, branch_stall_s, stall_s, taken_s;
  logic [ADDR_WIDTH-1:0] pc_s;
  logic                  flush_q_r;

  assign op_s    = instr_87[31:26];
  assign rs_s    = instr_87[25:21];
  assign rt_s    = instr_87[20:16];
  assign rd_s    = instr_87[15:11];
  assign funct_s = instr_87[5:0];
  // The wrong-path slot after a redirect and the all-zero word are both NOPs
  assign nop_s   = flush_q_r || (instr_87 == {INSTR_WIDTH{1'b0}});

  instr_decode_reg_file #(.REG_ADDR_W(REG_ADDR_W), .DATA_W(32)) u_reg_file (
    .clk     (clk_87),
    .rst_n   (rst_n_87),
    .we      (wb_we_87),
    .waddr   (wb_addr_87),
    .wdata   (wb_data_87),
    .raddr_a (rs_s),
    .raddr_b (rt_s),
    .rdata_a (rs_val_s),
    .rdata_b (rt_val_s)
  );

  // Instruction decode: control bundle, destination, immediate, operand usage
  always_comb begin
    ctrl_s     = {CTRL_W{1'b0}};
    dst_s      = R0;
    imm_s      = {{16{instr_87[15]}}, instr_87[15:0]};
    reads_rs_s = 1'b0;
    reads_rt_s = 1'b0;
    is_beq_s   = 1'b0;
    is_bne_s   = 1'b0;
    is_j_s     = 1'b0;
    if (!nop_s) begin
      case (op_s)
        OP_RTYPE: begin
          reads_rs_s = 1'b1;
          reads_rt_s = 1'b1;
          dst_s      = rd_s;
          case (funct_s)
            FN_ADD:  ctrl_s = pack_ctrl(ALU_ADD, rd_s != R0, 1'b0, 1'b0, 1'b0, 1'b0);
            FN_SUB:  ctrl_s = pack_ctrl(ALU_SUB, rd_s != R0, 1'b0, 1'b0, 1'b0, 1'b0);
            FN_AND:  ctrl_s = pack_ctrl(ALU_AND, rd_s != R0, 1'b0, 1'b0, 1'b0, 1'b0);
            FN_OR:   ctrl_s = pack_ctrl(ALU_OR,  rd_s != R0, 1'b0, 1'b0, 1'b0, 1'b0);
            FN_SLT:  ctrl_s = pack_ctrl(ALU_SLT, rd_s != R0, 1'b0, 1'b0, 1'b0, 1'b0);
            FN_SLL:  ctrl_s = pack_ctrl(ALU_SLL, rd_s != R0, 1'b0, 1'b0, 1'b0, 1'b0);
            FN_SRL:  ctrl_s = pack_ctrl(ALU_SRL, rd_s != R0, 1'b0, 1'b0, 1'b0, 1'b0);
            default: begin
              reads_rs_s = 1'b0;
              reads_rt_s = 1'b0;
              dst_s      = R0;
            end
          endcase
        end
        OP_ADDI: begin
          reads_rs_s = 1'b1;
          dst_s      = rt_s;
          ctrl_s     = pack_ctrl(ALU_ADD, rt_s != R0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        OP_ANDI: begin
          reads_rs_s = 1'b1;
          dst_s      = rt_s;
          imm_s      = {16'h0000, instr_87[15:0]};
          ctrl_s     = pack_ctrl(ALU_AND, rt_s != R0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        OP_ORI: begin
          reads_rs_s = 1'b1;
          dst_s      = rt_s;
          imm_s      = {16'h0000, instr_87[15:0]};
          ctrl_s     = pack_ctrl(ALU_OR, rt_s != R0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        OP_LW: begin
          reads_rs_s = 1'b1;
          dst_s      = rt_s;
          ctrl_s     = pack_ctrl(ALU_ADD, rt_s != R0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        OP_SW: begin
          reads_rs_s = 1'b1;
          reads_rt_s = 1'b1;
          ctrl_s     = pack_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        OP_BEQ: begin
          reads_rs_s = 1'b1;
          reads_rt_s = 1'b1;
          is_beq_s   = 1'b1;
        end
        OP_BNE: begin
          reads_rs_s = 1'b1;
          reads_rt_s = 1'b1;
          is_bne_s   = 1'b1;
        end
        OP_J: begin
          is_j_s = 1'b1;
        end
        default: begin
          ctrl_s = {CTRL_W{1'b0}};
        end
      endcase
    end else begin
      ctrl_s = {CTRL_W{1'b0}};
    end
  end

  // A load in EX feeding any source of this instruction
  assign load_use_s = id_ctrl_87[CTRL_MEM_READ] && (id_dst_87 != R0) &&
                      ((reads_rs_s && (id_dst_87 == rs_s)) || (reads_rt_s && (id_dst_87 == rt_s)));
  // Branches compare in ID, so any in-flight producer in EX or MEM must land first
  assign rs_hit_s = (rs_s != R0) && ((id_ctrl_87[CTRL_REG_WRITE] && (id_dst_87 == rs_s)) ||
                                     (mem_reg_write_87 && (mem_dst_87 == rs_s)));
  assign rt_hit_s = (rt_s != R0) && ((id_ctrl_87[CTRL_REG_WRITE] && (id_dst_87 == rt_s)) ||
                                     (mem_reg_write_87 && (mem_dst_87 == rt_s)));
  assign branch_stall_s = (is_beq_s || is_bne_s) && (rs_hit_s || rt_hit_s);
  assign stall_s        = load_use_s || branch_stall_s;

  // Branch/jump resolution; NOP and stalled cycles never redirect
  always_comb begin
    taken_s = 1'b0;
    pc_s    = {ADDR_WIDTH{1'b0}};
    if (!stall_s) begin
      if (is_j_s) begin
        taken_s = 1'b1;
        pc_s    = {npc_87[ADDR_WIDTH-1 -: 4], instr_87[25:0], 2'b00};
      end else if ((is_beq_s && (rs_val_s == rt_val_s)) || (is_bne_s && (rs_val_s != rt_val_s))) begin
        taken_s = 1'b1;
        pc_s    = npc_87 + {imm_s[ADDR_WIDTH-3:0], 2'b00};
      end else begin
        taken_s = 1'b0;
      end
    end else begin
      taken_s = 1'b0;
    end
  end

  assign stall_87 = stall_s;
  assign flush_87 = taken_s;
  assign sel_87   = taken_s;
  assign pc_87    = pc_s;

  // Wrong-path squash flag; held while stalled because fetch is held too
  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87) begin
      flush_q_r <= 1'b0;
    end else if (!stall_s) begin
      flush_q_r <= taken_s;
    end
  end

  // ID/EX register; stalls, NOPs, branches and jumps all issue a zeroed bubble
  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87) begin
      id_ctrl_87   <= {CTRL_W{1'b0}};
      id_rs_val_87 <= 32'd0;
      id_rt_val_87 <= 32'd0;
      id_imm_87    <= 32'd0;
      id_rs_87     <= R0;
      id_rt_87     <= R0;
      id_dst_87    <= R0;
      id_npc_87    <= {ADDR_WIDTH{1'b0}};
    end else if (stall_s || (ctrl_s == {CTRL_W{1'b0}})) begin
      id_ctrl_87   <= {CTRL_W{1'b0}};
      id_rs_val_87 <= 32'd0;
      id_rt_val_87 <= 32'd0;
      id_imm_87    <= 32'd0;
      id_rs_87     <= R0;
      id_rt_87     <= R0;
      id_dst_87    <= R0;
      id_npc_87    <= {ADDR_WIDTH{1'b0}};
    end else begin
      id_ctrl_87   <= ctrl_s;
      id_rs_val_87 <= rs_val_s;
      id_rt_val_87 <= rt_val_s;
      id_imm_87    <= imm_s;
      id_rs_87     <= rs_s;
      id_rt_87     <= rt_s;
      id_dst_87    <= dst_s;
      id_npc_87    <= npc_87;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: directed vectors push expectations into
// queues tagged with the cycle they are due; a monitor on the falling edge pops
// and compares fetch-control outputs (same cycle) and the ID/EX bundle (next cycle).
module tb_instr_decode;

  logic        clk_87 = 1'b0;
  logic        rst_n_87 = 1'b0;
  logic [31:0] instr_87 = 32'd0;
  logic [31:0] npc_87 = 32'd0;
  logic        wb_we_87 = 1'b0;
  logic [4:0]  wb_addr_87 = 5'd0;
  logic [31:0] wb_data_87 = 32'd0;
  logic        mem_reg_write_87 = 1'b0;
  logic [4:0]  mem_dst_87 = 5'd0;
  logic        stall_87, flush_87, sel_87;
  logic [31:0] pc_87;
  logic [8:0]  id_ctrl_87;
  logic [31:0] id_rs_val_87, id_rt_val_87, id_imm_87, id_npc_87;
  logic [4:0]  id_rs_87, id_rt_87, id_dst_87;

  instr_decode dut (
    .clk_87(clk_87), .rst_n_87(rst_n_87), .instr_87(instr_87), .npc_87(npc_87),
    .wb_we_87(wb_we_87), .wb_addr_87(wb_addr_87), .wb_data_87(wb_data_87),
    .mem_reg_write_87(mem_reg_write_87), .mem_dst_87(mem_dst_87),
    .stall_87(stall_87), .flush_87(flush_87), .sel_87(sel_87), .pc_87(pc_87),
    .id_ctrl_87(id_ctrl_87), .id_rs_val_87(id_rs_val_87), .id_rt_val_87(id_rt_val_87),
    .id_imm_87(id_imm_87), .id_rs_87(id_rs_87), .id_rt_87(id_rt_87),
    .id_dst_87(id_dst_87), .id_npc_87(id_npc_87)
  );

  always #5 clk_87 = ~clk_87;

  typedef struct {
    int          due;
    logic        stall, flush, sel;
    logic [31:0] pc;
  } comb_exp_t;

  typedef struct {
    int          due;
    bit          full;
    logic [8:0]  ctrl;
    logic [31:0] rsv, rtv, imm;
    logic [4:0]  rs, rt, dst;
    logic [31:0] npc;
  } id_exp_t;

  comb_exp_t comb_q[$];
  id_exp_t   id_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk_87) cyc <= cyc + 1;

  // Monitor: compare everything due in the current cycle
  always @(negedge clk_87) begin : monitor
    comb_exp_t c;
    id_exp_t   e;
    while (comb_q.size() > 0 && comb_q[0].due <= cyc) begin
      c = comb_q.pop_front();
      checks++;
      if (c.due != cyc || {stall_87, flush_87, sel_87, pc_87} !== {c.stall, c.flush, c.sel, c.pc}) begin
        errors++;
        $display("FAIL fetch_ctrl cyc %0d: got stall=%b flush=%b sel=%b pc=%08h, want stall=%b flush=%b sel=%b pc=%08h",
                 cyc, stall_87, flush_87, sel_87, pc_87, c.stall, c.flush, c.sel, c.pc);
      end
    end
    while (id_q.size() > 0 && id_q[0].due <= cyc) begin
      e = id_q.pop_front();
      checks++;
      if (e.due != cyc || id_ctrl_87 !== e.ctrl ||
          (e.full && {id_rs_val_87, id_rt_val_87, id_imm_87, id_rs_87, id_rt_87, id_dst_87, id_npc_87} !==
                     {e.rsv, e.rtv, e.imm, e.rs, e.rt, e.dst, e.npc})) begin
        errors++;
        $display("FAIL id_ex cyc %0d: got ctrl=%03h rs=%08h rt=%08h imm=%08h idx=%0d/%0d/%0d npc=%08h, want ctrl=%03h rs=%08h rt=%08h imm=%08h idx=%0d/%0d/%0d npc=%08h (full=%0d)",
                 cyc, id_ctrl_87, id_rs_val_87, id_rt_val_87, id_imm_87, id_rs_87, id_rt_87, id_dst_87, id_npc_87,
                 e.ctrl, e.rsv, e.rtv, e.imm, e.rs, e.rt, e.dst, e.npc, e.full);
      end
    end
  end

  task automatic step(input logic [31:0] instr, input logic [31:0] npc,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mrw, input logic [4:0] md, input logic rst);
    @(posedge clk_87);
    #1;
    rst_n_87 = rst;
    instr_87 = instr;
    npc_87 = npc;
    wb_we_87 = we;
    wb_addr_87 = wa;
    wb_data_87 = wd;
    mem_reg_write_87 = mrw;
    mem_dst_87 = md;
  endtask

  task automatic ec(input logic s, input logic f, input logic sl, input logic [31:0] pc);
    comb_exp_t c;
    c.due = cyc; c.stall = s; c.flush = f; c.sel = sl; c.pc = pc;
    comb_q.push_back(c);
  endtask

  task automatic ei(input int off, input bit full, input logic [8:0] ctrl,
                    input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                    input logic [31:0] npc);
    id_exp_t e;
    e.due = cyc + off; e.full = full; e.ctrl = ctrl; e.rsv = rsv; e.rtv = rtv; e.imm = imm;
    e.rs = rs; e.rt = rt; e.dst = dst; e.npc = npc;
    id_q.push_back(e);
  endtask

  // Bubble next cycle: only the control bundle is defined
  task automatic eb();
    ei(1, 1'b0, 9'h000, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  // Fully zero bundle at the given offset
  task automatic ez(input int off);
    ei(off, 1'b1, 9'h000, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  initial begin
    // Reset state
    step(32'h00000000, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    ec(1'b0, 1'b0, 1'b0, 32'h0); ez(1);
    // addi r1,r0,5
    step(32'h20010005, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h011, 32'd0, 32'd0, 32'd5, 5'd0, 5'd1, 5'd1, 32'h4);
    // add r2,r1,r1 with r1=5 written back this cycle
    step(32'h00211020, 32'h8, 1'b1, 5'd1, 32'd5, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h010, 32'd5, 32'd5, 32'h1020, 5'd1, 5'd1, 5'd2, 32'h8);
    // lw r3,0(r0)
    step(32'h8C030000, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h01B, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3, 32'hC);
    // add r4,r3,r3: load-use stall, zeroed bubble
    step(32'h00632020, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b1, 1'b0, 1'b0, 32'h0); ez(1);
    // same add re-decoded, r3=0x33 arriving via bypass
    step(32'h00632020, 32'h10, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h010, 32'h33, 32'h33, 32'h2020, 5'd3, 5'd3, 5'd4, 32'h10);
    // NOPs while writing r1=7, r2=7
    step(32'h00000000, 32'h14, 1'b1, 5'd1, 32'd7, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); eb();
    step(32'h00000000, 32'h14, 1'b1, 5'd2, 32'd7, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); eb();
    // beq r1,r2,3 taken -> 0x20
    step(32'h10220003, 32'h14, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b1, 1'b1, 32'h20); eb();
    // wrong-path addi is squashed
    step(32'h20010005, 32'h18, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); eb();
    // beq r1,r3 not taken (7 vs 0x33)
    step(32'h10230003, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); eb();
    // j 0x40 at npc 0x10000004
    step(32'h08000040, 32'h10000004, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b1, 1'b1, 32'h10000100); eb();
    // wrong-path add squashed
    step(32'h00211020, 32'h10000008, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); eb();
    // bne r0,r1,-1 at npc 0 -> wraps to 0xFFFFFFFC
    step(32'h1401FFFF, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC); eb();
    step(32'h00000000, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); eb();
    // beq r5,r0,2 with r5 pending in MEM: stall, then taken to 0x48
    step(32'h10A00002, 32'h40, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1);
    ec(1'b1, 1'b0, 1'b0, 32'h0); ez(1);
    step(32'h10A00002, 32'h40, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b1, 1'b1, 32'h48); eb();
    step(32'h00003020, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); eb();
    // add r6,r0,r5: r0 still reads 0 after the write attempt
    step(32'h00053020, 32'h4C, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h010, 32'd0, 32'd0, 32'h3020, 5'd0, 5'd5, 5'd6, 32'h4C);
    // ori r7,r0,0x8001 zero-extended
    step(32'h34078001, 32'h50, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h071, 32'd0, 32'd0, 32'h00008001, 5'd0, 5'd7, 5'd7, 32'h50);
    // sw r1,-4(r3)
    step(32'hAC61FFFC, 32'h54, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h005, 32'h33, 32'd7, 32'hFFFFFFFC, 5'd3, 5'd1, 5'd0, 32'h54);
    // sub r0,r1,r1: destination 0 suppresses reg_write
    step(32'h00210022, 32'h58, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h020, 32'd7, 32'd7, 32'h22, 5'd1, 5'd1, 5'd0, 32'h58);
    // and r8,r1,r3
    step(32'h00234024, 32'h5C, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h050, 32'd7, 32'h33, 32'h4024, 5'd1, 5'd3, 5'd8, 32'h5C);
    // unsupported opcode -> bubble
    step(32'hFC000000, 32'h60, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); eb();
    // ori r8,r0,1 loads ID/EX with a nonzero bundle ahead of reset
    step(32'h34080001, 32'h64, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    // addi pending, async reset asserted mid-cycle
    step(32'h20010005, 32'h68, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0); ez(0); ez(1);
    #1 rst_n_87 = 1'b0;
    step(32'h00000000, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    ec(1'b0, 1'b0, 1'b0, 32'h0); ez(1);
    // after release r1, r2, r3 read 0
    step(32'h00224820, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h010, 32'd0, 32'd0, 32'h4820, 5'd1, 5'd2, 5'd9, 32'h100);
    step(32'h00615020, 32'h104, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    ei(1, 1'b1, 9'h010, 32'd0, 32'd0, 32'h5020, 5'd3, 5'd1, 5'd10, 32'h104);
    step(32'h00000000, 32'h108, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    ec(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk_87);
    #1;
    checks++;
    if (comb_q.size() + id_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", comb_q.size() + id_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
